// File: rtl/board_pkg.sv
// Shared board definitions: piece codes, read-port owner encodings, FSM states and
// layout helpers used by the board datapath.
package board_pkg;

  localparam int unsigned PieceW = 4;
  localparam int unsigned CoordW = 3;
  localparam int unsigned AddrW  = 2 * CoordW;

  localparam logic [PieceW-1:0] PIECE_EMPTY  = 4'd0;
  localparam logic [PieceW-1:0] WIN_PIECE_P0 = 4'd6;
  localparam logic [PieceW-1:0] WIN_PIECE_P1 = 4'd12;

  localparam logic [1:0] MM_CONTROL   = 2'b00;
  localparam logic [1:0] MM_VALIDATOR = 2'b01;
  localparam logic [1:0] MM_DATAPATH  = 2'b10;
  localparam logic [1:0] MM_VIEW      = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StInitDone,
    StMoveClear,
    StMoveWrite
  } state_e;

  function automatic logic [AddrW-1:0] board_addr(input logic [CoordW-1:0] x,
                                                  input logic [CoordW-1:0] y);
    return {y, x};
  endfunction

  // Back rank of player 0; player 1 mirrors it with codes offset by 6.
  function automatic logic [PieceW-1:0] back_rank(input logic [CoordW-1:0] x);
    logic [PieceW-1:0] p;
    case (x)
      3'd0, 3'd7: p = 4'd1;
      3'd1, 3'd6: p = 4'd2;
      3'd2, 3'd5: p = 4'd3;
      3'd3:       p = 4'd4;
      default:    p = WIN_PIECE_P0;
    endcase
    return p;
  endfunction

  function automatic logic [PieceW-1:0] initial_piece(input logic [AddrW-1:0] addr);
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
    logic [PieceW-1:0] p;
    x = addr[CoordW-1:0];
    y = addr[AddrW-1:CoordW];
    case (y)
      3'd0:    p = back_rank(x);
      3'd1:    p = 4'd5;
      3'd6:    p = 4'd11;
      3'd7:    p = (x == 3'd4) ? WIN_PIECE_P1 : back_rank(x) + 4'd6;
      default: p = PIECE_EMPTY;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/board_ram.sv
// Board cell storage: asynchronous read, synchronous single-port write.
module board_ram #(
  parameter int unsigned DataW = 4,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [DataW-1:0] rdata
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];

  // No reset: contents are defined only by the init sequence.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/board_datapath.sv
// Board-side responder: owns the board RAM, runs the init fill and two-step moves,
// and multiplexes the single read port between its four agents.
module board_datapath
  import board_pkg::*;
#(
  parameter int unsigned PIECE_W = 4,
  parameter int unsigned COORD_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 initialize_board,
  input  logic                 move_piece,
  input  logic [COORD_W-1:0]   piece_x,
  input  logic [COORD_W-1:0]   piece_y,
  input  logic [COORD_W-1:0]   move_x,
  input  logic [COORD_W-1:0]   move_y,
  input  logic [PIECE_W-1:0]   piece_to_move,
  input  logic [1:0]           memory_manage,
  input  logic [COORD_W-1:0]   box_x,
  input  logic [COORD_W-1:0]   box_y,
  input  logic [2*COORD_W-1:0] address_validator,
  input  logic [2*COORD_W-1:0] address_view,
  output logic [PIECE_W-1:0]   piece_read,
  output logic                 initialize_complete,
  output logic                 move_complete,
  output logic                 busy
);

  localparam int unsigned AW = 2 * COORD_W;

  state_e         state_q, state_d;
  logic [AW-1:0]  counter_q, counter_d;
  logic [AW-1:0]  src_q, src_d;
  logic [AW-1:0]  dst_q, dst_d;
  logic [PIECE_W-1:0] piece_q, piece_d;
  logic           move_complete_q, move_complete_d;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [PIECE_W-1:0] wr_data;
  logic [AW-1:0]      rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      counter_q       <= '0;
      src_q           <= '0;
      dst_q           <= '0;
      piece_q         <= '0;
      move_complete_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      counter_q       <= counter_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      piece_q         <= piece_d;
      move_complete_q <= move_complete_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    counter_d       = counter_q;
    src_d           = src_q;
    dst_d           = dst_q;
    piece_d         = piece_q;
    move_complete_d = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = dst_q;
    wr_data         = PIECE_EMPTY;

    unique case (state_q)
      StIdle: begin
        // Init takes priority; a simultaneous move request is dropped.
        if (initialize_board) begin
          state_d   = StInit;
          counter_d = '0;
        end else if (move_piece) begin
          src_d   = board_addr(piece_x, piece_y);
          dst_d   = board_addr(move_x, move_y);
          piece_d = piece_to_move;
          state_d = StMoveClear;
        end
      end
      StInit: begin
        wr_en     = 1'b1;
        wr_addr   = counter_q;
        wr_data   = initial_piece(counter_q);
        counter_d = counter_q + 1'b1;
        if (counter_q == '1) begin
          state_d = StInitDone;
        end
      end
      StInitDone: begin
        if (!initialize_board) begin
          state_d = StIdle;
        end
      end
      StMoveClear: begin
        wr_en   = 1'b1;
        wr_addr = src_q;
        wr_data = PIECE_EMPTY;
        state_d = StMoveWrite;
      end
      StMoveWrite: begin
        wr_en           = 1'b1;
        wr_addr         = dst_q;
        wr_data         = piece_q;
        move_complete_d = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_addr = '0;
    unique case (memory_manage)
      MM_CONTROL:   rd_addr = board_addr(box_x, box_y);
      MM_VALIDATOR: rd_addr = address_validator;
      MM_DATAPATH:  rd_addr = wr_addr;
      MM_VIEW:      rd_addr = address_view;
      default:      rd_addr = '0;
    endcase
  end

  board_ram #(
    .DataW(PIECE_W),
    .AddrW(AW)
  ) u_board_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(piece_read)
  );

  assign busy                = (state_q != StIdle);
  assign initialize_complete = (state_q == StInitDone) && initialize_board;
  assign move_complete       = move_complete_q;

endmodule

// File: tb/tb_board_datapath.sv
// Directed bench for board_datapath: expected read data queued at stimulus time and
// compared against piece_read, with a cell-level reference board.
module tb_board_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic       initialize_board;
  logic       move_piece;
  logic [2:0] piece_x, piece_y, move_x, move_y;
  logic [3:0] piece_to_move;
  logic [1:0] memory_manage;
  logic [2:0] box_x, box_y;
  logic [5:0] address_validator, address_view;
  logic [3:0] piece_read;
  logic       initialize_complete;
  logic       move_complete;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int model[64];

  always #5 clk = ~clk;

  board_datapath dut (
    .clk                (clk),
    .reset              (reset),
    .initialize_board   (initialize_board),
    .move_piece         (move_piece),
    .piece_x            (piece_x),
    .piece_y            (piece_y),
    .move_x             (move_x),
    .move_y             (move_y),
    .piece_to_move      (piece_to_move),
    .memory_manage      (memory_manage),
    .box_x              (box_x),
    .box_y              (box_y),
    .address_validator  (address_validator),
    .address_view       (address_view),
    .piece_read         (piece_read),
    .initialize_complete(initialize_complete),
    .move_complete      (move_complete),
    .busy               (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Queue the expected read value, let the mux settle, then pop and compare.
  task automatic rd(input string tag, input int exp);
    int e;
    exp_q.push_back(exp);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_queue"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, int'(piece_read), e);
    end
  endtask

  function automatic int ref_piece(input int a);
    int back[8];
    int x;
    int y;
    back = '{1, 2, 3, 4, 6, 3, 2, 1};
    x = a % 8;
    y = a / 8;
    if (y == 0) return back[x];
    if (y == 1) return 5;
    if (y == 6) return 11;
    if (y == 7) return back[x] + 6;
    return 0;
  endfunction

  task automatic model_init();
    for (int a = 0; a < 64; a++) model[a] = ref_piece(a);
  endtask

  // Counts ticks (including the sampling edge) until initialize_complete rises.
  task automatic wait_init(output int n, output int mc_seen);
    n = 0;
    mc_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (move_complete) mc_seen++;
      if (initialize_complete) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic sweep_view(input string tag);
    memory_manage = 2'b11;
    for (int a = 0; a < 64; a++) begin
      address_view = 6'(a);
      rd($sformatf("%s_cell%0d", tag, a), model[a]);
    end
  endtask

  task automatic drive_move(input int sx, input int sy, input int dx, input int dy,
                            input int p);
    move_piece    = 1'b1;
    piece_x       = 3'(sx);
    piece_y       = 3'(sy);
    move_x        = 3'(dx);
    move_y        = 3'(dy);
    piece_to_move = 4'(p);
  endtask

  initial begin
    int n;
    int mc;
    reset = 1'b1;
    initialize_board = 1'b0;
    move_piece = 1'b0;
    piece_x = '0; piece_y = '0; move_x = '0; move_y = '0; piece_to_move = '0;
    memory_manage = 2'b00;
    box_x = '0; box_y = '0;
    address_validator = '0; address_view = '0;

    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_init_complete", int'(initialize_complete), 0);
    check("rst_move_complete", int'(move_complete), 0);
    reset = 1'b0;

    // Init fill
    initialize_board = 1'b1;
    wait_init(n, mc);
    check("init_latency", n, 65);
    check("init_busy", int'(busy), 1);
    model_init();
    memory_manage = 2'b11;
    address_view = 6'd4;  rd("view_a4", 6);
    address_view = 6'd60; rd("view_a60", 12);
    address_view = 6'd8;  rd("view_a8", 5);
    tick();
    address_view = 6'd27; rd("view_a27", 0);
    sweep_view("init");
    initialize_board = 1'b0;
    #1;
    check("init_release_same_cycle", int'(initialize_complete), 0);
    tick();
    check("idle_busy", int'(busy), 0);

    // Basic move (1,1) -> (1,3)
    memory_manage = 2'b00;
    box_x = 3'd1; box_y = 3'd1;
    drive_move(1, 1, 1, 3, 5);
    tick();
    move_piece = 1'b0;
    check("move_busy", int'(busy), 1);
    tick();
    rd("move_src_cleared", 0);
    check("move_mc_early", int'(move_complete), 0);
    tick();
    check("move_mc_pulse", int'(move_complete), 1);
    box_y = 3'd3;
    rd("move_dst_written", 5);
    tick();
    check("move_mc_single", int'(move_complete), 0);
    model[9] = 0;
    model[25] = 5;

    // Same-square move at (4,0)
    box_x = 3'd4; box_y = 3'd0;
    drive_move(4, 0, 4, 0, 6);
    tick();
    move_piece = 1'b0;
    tick();
    rd("same_sq_after_clear", 0);
    tick();
    check("same_sq_mc", int'(move_complete), 1);
    rd("same_sq_final", 6);
    model[4] = 6;

    // Read mux, each owner in the same cycle
    tick();
    address_validator = 6'd60;
    address_view = 6'd0;
    box_x = 3'd7; box_y = 3'd7;
    memory_manage = 2'b01; rd("mux_validator", model[60]);
    memory_manage = 2'b11; rd("mux_view", model[0]);
    memory_manage = 2'b00; rd("mux_control", model[63]);

    // Second move during MOVE_CLEAR is ignored
    tick();
    memory_manage = 2'b10;
    drive_move(0, 6, 0, 4, 11);
    tick();
    drive_move(7, 6, 7, 4, 11);
    rd("dp_read_src", model[48]);
    tick();
    move_piece = 1'b0;
    rd("dp_read_dst", model[32]);
    tick();
    check("collide_mc", int'(move_complete), 1);
    model[48] = 0;
    model[32] = 11;
    memory_manage = 2'b00;
    box_x = 3'd0; box_y = 3'd4; rd("collide_dst1", model[32]);
    box_x = 3'd0; box_y = 3'd6; rd("collide_src1", model[48]);
    box_x = 3'd7; box_y = 3'd6; rd("collide_src2_kept", model[55]);
    box_x = 3'd7; box_y = 3'd4; rd("collide_dst2_empty", model[39]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("collide_no_mc%0d", i), int'(move_complete), 0);
    end

    // Init and move together: init wins, move dropped
    initialize_board = 1'b1;
    drive_move(3, 1, 3, 3, 5);
    wait_init(n, mc);
    check("both_init_latency", n, 65);
    check("both_no_move_complete", mc, 0);
    model_init();
    move_piece = 1'b0;
    box_x = 3'd3; box_y = 3'd1; rd("both_src_kept", model[11]);
    box_x = 3'd3; box_y = 3'd3; rd("both_dst_empty", model[27]);
    initialize_board = 1'b0;
    tick();
    check("both_mc_after", int'(move_complete), 0);

    // Reset at counter=20, then full re-init
    initialize_board = 1'b1;
    tick();
    repeat (20) tick();
    reset = 1'b1;
    tick();
    check("midinit_rst_busy", int'(busy), 0);
    check("midinit_rst_init_complete", int'(initialize_complete), 0);
    check("midinit_rst_move_complete", int'(move_complete), 0);
    reset = 1'b0;
    wait_init(n, mc);
    check("reinit_latency", n, 65);
    check("reinit_complete", int'(initialize_complete), 1);
    sweep_view("reinit");
    initialize_board = 1'b0;
    tick();
    check("reinit_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
